// File: rtl/garip_sifreleme_pkg.sv
// Shared definitions for the serial encryption block, its receiver and their benches.
package garip_sifreleme_pkg;

    localparam int unsigned BIT_VARSAYILAN = 4;

    typedef enum logic [0:0] {
        BOSTA = 1'b0,
        TOPLA = 1'b1
    } durum_t;

endpackage

// File: rtl/seri_paralel_alici_if.sv
// Serial-in / word-out signal bundle of the receiver; slave is the receiver side.
interface seri_paralel_alici_if #(
    parameter int unsigned BIT = garip_sifreleme_pkg::BIT_VARSAYILAN
) ();

    logic           bit_girisi;
    logic           gecerli_girisi;
    logic [BIT-1:0] veri_cikisi;
    logic           cikis_gecerli;
    logic           cikis_hazir;
    logic           hata;
    logic           tasma;

    modport master (
        output bit_girisi,
        output gecerli_girisi,
        output cikis_hazir,
        input  veri_cikisi,
        input  cikis_gecerli,
        input  hata,
        input  tasma
    );

    modport slave (
        input  bit_girisi,
        input  gecerli_girisi,
        input  cikis_hazir,
        output veri_cikisi,
        output cikis_gecerli,
        output hata,
        output tasma
    );

endinterface

// File: rtl/seri_paralel_alici_kucuk_fifo.sv
// Small synchronous FIFO with a registered show-ahead output; the output holds its
// last value once the FIFO drains.
module kucuk_fifo #(
    parameter int unsigned GENISLIK = 4,
    parameter int unsigned DERINLIK = 4
) (
    input  logic                saat,
    input  logic                reset,
    input  logic                push,
    input  logic [GENISLIK-1:0] push_veri,
    input  logic                pop,
    output logic [GENISLIK-1:0] cikis_veri,
    output logic                dolu,
    output logic                bos
);

    localparam int unsigned PW = $clog2(DERINLIK);

    logic [GENISLIK-1:0] bellek_q [DERINLIK];
    logic [PW-1:0]       yaz_q, oku_q, oku_sonraki;
    logic [PW:0]         adet_q;
    logic [GENISLIK-1:0] cikis_q;
    logic                yaz_ok, pop_ok;

    assign dolu        = (adet_q == (PW+1)'(DERINLIK));
    assign bos         = (adet_q == '0);
    assign pop_ok      = pop && !bos;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign yaz_ok      = push && (!dolu || pop_ok);
    assign oku_sonraki = oku_q + PW'(1);
    assign cikis_veri  = cikis_q;

    always_ff @(posedge saat) begin
        if (yaz_ok) begin
            bellek_q[yaz_q] <= push_veri;
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            yaz_q   <= '0;
            oku_q   <= '0;
            adet_q  <= '0;
            cikis_q <= '0;
        end else begin
            if (yaz_ok) yaz_q <= yaz_q + PW'(1);
            if (pop_ok) oku_q <= oku_sonraki;
            case ({yaz_ok, pop_ok})
                2'b10:   adet_q <= adet_q + (PW+1)'(1);
                2'b01:   adet_q <= adet_q - (PW+1)'(1);
                default: adet_q <= adet_q;
            endcase
            // Track the next head; hold the last word when nothing replaces it.
            if (bos && yaz_ok) begin
                cikis_q <= push_veri;
            end else if (pop_ok) begin
                if (adet_q >= (PW+1)'(2)) cikis_q <= bellek_q[oku_sonraki];
                else if (yaz_ok)          cikis_q <= push_veri;
            end
        end
    end

endmodule

// File: rtl/seri_paralel_alici.sv
// LSB-first serial-to-parallel receiver with word FIFO, truncation and overflow flags.
// Optional event counters enabled by SERI_ALICI_SAYAC_EN.
module seri_paralel_alici
    import garip_sifreleme_pkg::*;
#(
    parameter int unsigned BIT      = BIT_VARSAYILAN,
    parameter int unsigned DERINLIK = 4
) (
    input  logic                 saat,
    input  logic                 reset,
    seri_paralel_alici_if.slave  bus
`ifdef SERI_ALICI_SAYAC_EN
    ,
    output logic [7:0]           kelime_sayisi,
    output logic [7:0]           hata_sayisi
`endif
);

    localparam int unsigned SW = (BIT > 1) ? $clog2(BIT) : 1;
    localparam logic [SW-1:0] SON = SW'(BIT - 1);

    durum_t         durum_q, durum_d;
    logic [SW-1:0]  sayac_q, sayac_d;
    logic [BIT-1:0] kelime_q, kelime_d, tam_kelime;
    logic           push, pop, dolu, bos;
    logic           hata_d, hata_q, tasma_d, tasma_q;

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q  <= BOSTA;
            sayac_q  <= '0;
            kelime_q <= '0;
            hata_q   <= 1'b0;
            tasma_q  <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            sayac_q  <= sayac_d;
            kelime_q <= kelime_d;
            hata_q   <= hata_d;
            tasma_q  <= tasma_d;
        end
    end

    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        unique case (durum_q)
            BOSTA: begin
                if (bus.gecerli_girisi) begin
                    sayac_d = SW'(1);
                    durum_d = TOPLA;
                end
            end
            TOPLA: begin
                if (bus.gecerli_girisi && sayac_q != SON) begin
                    sayac_d = sayac_q + SW'(1);
                end else begin
                    sayac_d = '0;
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_comb begin
        // sayac_q is 0 in BOSTA, so the same insert handles the first bit.
        tam_kelime          = kelime_q;
        tam_kelime[sayac_q] = bus.bit_girisi;
        kelime_d            = bus.gecerli_girisi ? tam_kelime : kelime_q;
        push                = (durum_q == TOPLA) && bus.gecerli_girisi && (sayac_q == SON);
        hata_d              = (durum_q == TOPLA) && !bus.gecerli_girisi;
        pop                 = bus.cikis_hazir && !bos;
        tasma_d             = push && dolu && !pop;
    end

    kucuk_fifo #(
        .GENISLIK (BIT),
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .saat       (saat),
        .reset      (reset),
        .push       (push),
        .push_veri  (tam_kelime),
        .pop        (bus.cikis_hazir),
        .cikis_veri (bus.veri_cikisi),
        .dolu       (dolu),
        .bos        (bos)
    );

    assign bus.cikis_gecerli = !bos;
    assign bus.hata          = hata_q;
    assign bus.tasma         = tasma_q;

`ifdef SERI_ALICI_SAYAC_EN
    logic [7:0] kelime_say_q, hata_say_q;

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            kelime_say_q <= '0;
            hata_say_q   <= '0;
        end else begin
            if (push && !tasma_d) kelime_say_q <= kelime_say_q + 8'd1;
            // hata and tasma are mutually exclusive: one needs gecerli low, the other high.
            if ((hata_d || tasma_d) && hata_say_q != 8'hFF) hata_say_q <= hata_say_q + 8'd1;
        end
    end

    assign kelime_sayisi = kelime_say_q;
    assign hata_sayisi   = hata_say_q;
`endif

endmodule

// File: tb/tb_seri_paralel_alici.sv
// Directed bench for seri_paralel_alici (BIT=4, DERINLIK=2).
module tb_seri_paralel_alici;

    localparam int unsigned BIT      = 4;
    localparam int unsigned DERINLIK = 2;

    logic saat = 1'b0;
    logic reset;
    always #5 saat = ~saat;

    seri_paralel_alici_if #(.BIT(BIT)) bus ();

`ifdef SERI_ALICI_SAYAC_EN
    logic [7:0] kelime_sayisi, hata_sayisi;
`endif

    seri_paralel_alici #(
        .BIT      (BIT),
        .DERINLIK (DERINLIK)
    ) dut (
        .saat          (saat),
        .reset         (reset),
        .bus           (bus)
`ifdef SERI_ALICI_SAYAC_EN
        ,
        .kelime_sayisi (kelime_sayisi),
        .hata_sayisi   (hata_sayisi)
`endif
    );

    int checks = 0;
    int errors = 0;
    int hata_adet = 0;
    int tasma_adet = 0;
    int onceki;

    always @(negedge saat) begin
        if (bus.hata === 1'b1)  hata_adet++;
        if (bus.tasma === 1'b1) tasma_adet++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge saat);
        #1;
    endtask

    task automatic cerceve(input logic [BIT-1:0] w, input logic hazir_son);
        for (int i = 0; i < BIT; i++) begin
            bus.bit_girisi     = w[i];
            bus.gecerli_girisi = 1'b1;
            bus.cikis_hazir    = (i == BIT - 1) ? hazir_son : 1'b0;
            tick();
        end
        bus.gecerli_girisi = 1'b0;
        bus.bit_girisi     = 1'b0;
        bus.cikis_hazir    = 1'b0;
    endtask

    task automatic pop_one();
        bus.cikis_hazir = 1'b1;
        tick();
        bus.cikis_hazir = 1'b0;
    endtask

    initial begin
        bus.bit_girisi     = 1'b0;
        bus.gecerli_girisi = 1'b0;
        bus.cikis_hazir    = 1'b0;
        reset              = 1'b0;
        #12;
        check_eq("rst_veri",    bus.veri_cikisi,   0);
        check_eq("rst_gecerli", bus.cikis_gecerli, 0);
        check_eq("rst_hata",    bus.hata,          0);
        check_eq("rst_tasma",   bus.tasma,         0);
        reset = 1'b1;
        tick();

        // Single frame 0,0,1,0 -> 4
        cerceve(4'd4, 1'b0);
        check_eq("tek_veri",    bus.veri_cikisi,   4);
        check_eq("tek_gecerli", bus.cikis_gecerli, 1);
        check_eq("tek_hata",    bus.hata,          0);
        pop_one();
        check_eq("tek_bos",     bus.cikis_gecerli, 0);
        check_eq("tek_tut",     bus.veri_cikisi,   4);

        // Upstream-chain words 4 then 9
        cerceve(4'd4, 1'b0);
        cerceve(4'd9, 1'b0);
        check_eq("zincir_1",     bus.veri_cikisi,   4);
        pop_one();
        check_eq("zincir_2",     bus.veri_cikisi,   9);
        pop_one();
        check_eq("zincir_bos",   bus.cikis_gecerli, 0);
        check_eq("zincir_hata",  hata_adet,         0);
        check_eq("zincir_tasma", tasma_adet,        0);

        // Back-to-back 1,0,0,1,1,1,1,1 -> 9, 15 retained while not ready
        cerceve(4'd9, 1'b0);
        cerceve(4'd15, 1'b0);
        tick();
        tick();
        check_eq("ardisik_tut", bus.veri_cikisi,   9);
        check_eq("ardisik_gec", bus.cikis_gecerli, 1);
        pop_one();
        check_eq("ardisik_2",   bus.veri_cikisi,   15);
        pop_one();
        check_eq("ardisik_bos", bus.cikis_gecerli, 0);

        // Truncated frame after 2 bits
        onceki             = hata_adet;
        bus.gecerli_girisi = 1'b1;
        bus.bit_girisi     = 1'b1;
        tick();
        tick();
        bus.gecerli_girisi = 1'b0;
        bus.bit_girisi     = 1'b0;
        tick();
        check_eq("kesik_hata",   bus.hata,          1);
        check_eq("kesik_bos",    bus.cikis_gecerli, 0);
        tick();
        check_eq("kesik_hata0",  bus.hata,          0);
        check_eq("kesik_darbe",  hata_adet - onceki, 1);
        cerceve(4'd10, 1'b0);
        check_eq("kesik_sonra",  bus.veri_cikisi,   10);
        pop_one();

        // Overflow: third word dropped
        onceki = tasma_adet;
        cerceve(4'd1, 1'b0);
        cerceve(4'd2, 1'b0);
        cerceve(4'd3, 1'b0);
        check_eq("tasma_1",     bus.tasma,           1);
        tick();
        check_eq("tasma_0",     bus.tasma,           0);
        check_eq("tasma_darbe", tasma_adet - onceki, 1);
        check_eq("tasma_oku1",  bus.veri_cikisi,     1);
        pop_one();
        check_eq("tasma_oku2",  bus.veri_cikisi,     2);
        pop_one();
        check_eq("tasma_bos",   bus.cikis_gecerli,   0);

        // Full with simultaneous pop: push accepted
        onceki = tasma_adet;
        cerceve(4'd1, 1'b0);
        cerceve(4'd2, 1'b0);
        cerceve(4'd3, 1'b1);
        check_eq("esz_tasma",  bus.tasma,         0);
        check_eq("esz_oku1",   bus.veri_cikisi,   2);
        check_eq("esz_gec",    bus.cikis_gecerli, 1);
        pop_one();
        check_eq("esz_oku2",   bus.veri_cikisi,   3);
        pop_one();
        check_eq("esz_bos",    bus.cikis_gecerli, 0);
        check_eq("esz_darbe",  tasma_adet - onceki, 0);

        // Reset mid-frame with a word in the FIFO
        cerceve(4'd5, 1'b0);
        check_eq("rst2_once", bus.veri_cikisi, 5);
        onceki             = hata_adet;
        bus.gecerli_girisi = 1'b1;
        bus.bit_girisi     = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst2_veri",    bus.veri_cikisi,   0);
        check_eq("rst2_gecerli", bus.cikis_gecerli, 0);
        check_eq("rst2_hata",    bus.hata,          0);
        check_eq("rst2_tasma",   bus.tasma,         0);
        bus.gecerli_girisi = 1'b0;
        bus.bit_girisi     = 1'b0;
        @(posedge saat);
        #3;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst2_darbe",   hata_adet - onceki, 0);
        cerceve(4'd3, 1'b0);
        check_eq("rst2_sonra",   bus.veri_cikisi,   3);
        check_eq("rst2_sgec",    bus.cikis_gecerli, 1);

`ifdef SERI_ALICI_SAYAC_EN
        check_eq("say_kelime", kelime_sayisi, 1);
        check_eq("say_hata",   hata_sayisi,   0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seri_paralel_alici.md
Name: seri_paralel_alici

Overview:
- Receiver stage directly downstream of the serial encryption block.
- Samples the serial encrypted stream (bit_cikisi / gecerli of the encryption block) LSB-first and reassembles BIT-bit words.
- Buffers completed words in a small FIFO and hands them to the consumer over a valid/ready handshake.
- Flags truncated frames and FIFO overflow.

Parameters:
- BIT, 4, word width; must match the upstream encryption block.
- DERINLIK, 4, FIFO depth in words; power of two, ≥2.

Ports:
- saat  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- bit_girisi  input  1  serial data bit; connects to upstream bit_cikisi.
- gecerli_girisi  input  1  bit valid; connects to upstream gecerli.
- veri_cikisi  output  BIT  head-of-FIFO word.
- cikis_gecerli  output  1  FIFO non-empty; veri_cikisi is valid.
- cikis_hazir  input  1  consumer ready; a pop occurs on a cycle where cikis_gecerli && cikis_hazir.
- hata  output  1  one-cycle pulse: frame truncated.
- tasma  output  1  one-cycle pulse: completed word dropped because the FIFO was full.

Behaviour:
- Reset values: veri_cikisi=0, cikis_gecerli=0, hata=0, tasma=0. FIFO is empty, bit counter=0, FSM in BOSTA.
- A bit is sampled on each rising edge with gecerli_girisi=1. The first sampled bit goes to bit 0 (LSB-first).
- FSM states:
  - BOSTA: if gecerli_girisi=1, capture the bit into position 0, set sayac=1, go to TOPLA. Otherwise stay.
  - TOPLA, gecerli_girisi=1: capture into position sayac.
    - If sayac==BIT-1, the word is complete: push to the FIFO, set sayac=0, go to BOSTA.
    - Otherwise increment sayac.
  - TOPLA, gecerli_girisi=0: discard the partial word, pulse hata for one cycle, set sayac=0, go to BOSTA.
- Back-to-back frames: gecerli_girisi held high for 2*BIT cycles yields two words. The BOSTA capture on the very next cycle makes this seamless.
- Latency: a completed word appears on veri_cikisi with cikis_gecerli=1 on the cycle after its last bit is sampled (registered FIFO, show-ahead output).
- FIFO:
  - Pointers are $clog2(DERINLIK) bits and wrap naturally.
  - Occupancy is $clog2(DERINLIK)+1 bits.
  - veri_cikisi holds its value while cikis_gecerli=1 and cikis_hazir=0.
  - When the FIFO is empty, veri_cikisi holds its last value (0 after reset).
- Full boundary: a completed word arriving while the FIFO is full is dropped and tasma pulses.
  - Exception: if a pop happens in the same cycle, the push succeeds and tasma stays 0.
- Empty boundary: cikis_hazir while empty has no effect.
- Simultaneous push and pop with a non-empty FIFO: occupancy is unchanged.
- Reset asserted mid-frame or mid-FIFO: all state clears asynchronously. No hata pulse is generated for the aborted frame.

Optional Feature:
- Macro: SERI_ALICI_SAYAC_EN.
- When defined:
  - Adds output kelime_sayisi[7:0]: count of words successfully pushed, wraps 255→0.
  - Adds output hata_sayisi[7:0]: count of hata plus tasma events, saturating at 255.
  - Both reset to 0.
- When undefined: neither port nor its logic exists. Core behaviour is identical.

Decomposition:
- Shared package/include garip_sifreleme_pkg holds:
  - FSM state encodings BOSTA=0, TOPLA=1.
  - The default BIT=4, so encryption block, receiver and benches stay consistent.
- Sub-module kucuk_fifo (parameters GENISLIK, DERINLIK): synchronous FIFO with show-ahead output, push/pop/dolu/bos. The receiver instantiates it with GENISLIK=BIT.

Test Plan:
- Single frame: gecerli_girisi=1 for 4 cycles with bits 0,0,1,0 → next cycle veri_cikisi=4, cikis_gecerli=1. With cikis_hazir=1 for one cycle, cikis_gecerli=0 afterwards.
- Upstream chain: connect to the encryption block with (mod=1, veri=11, secim=7) then (mod=0, veri=6, secim=3) → words 4 then 9 are read out in order. No hata, no tasma.
- Back-to-back: gecerli_girisi high 8 cycles, bits 1,0,0,1,1,1,1,1 → FIFO holds 9 then 15. With cikis_hazir=0, both are retained and veri_cikisi stays 9.
- Truncated frame: gecerli_girisi high 2 cycles then low → hata=1 for exactly one cycle, FIFO stays empty. The next full frame 0,1,0,1 gives 10.
- Overflow, DERINLIK=2, cikis_hazir=0:
  - Push 3 words (1,2,3) → tasma pulses on the third; readout yields 1,2.
  - Repeat with cikis_hazir=1 on the third-push cycle → no tasma; readout yields 2,3.
- Reset mid-frame: drive reset=0 after 2 bits of a frame → all outputs 0 at once, no hata. After release, a full frame 1,1,0,0 gives 3.
